// File: rtl/serial_capture_sequencer_if.sv
// Handshake and data bundle between the pad wrapper (master) and the
// capture/playback sequencer (slave).
interface serial_capture_sequencer_if;
    logic       start;
    logic       abort;
    logic       ser_in;
    logic [7:0] offset;
    logic       busy;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       done;

    modport master (
        output start, abort, ser_in, offset,
        input  busy, out_valid, out_byte, done
    );

    modport slave (
        input  start, abort, ser_in, offset,
        output busy, out_valid, out_byte, done
    );
endinterface

// File: rtl/serial_capture_sequencer.sv
// Tick-paced sequencer: shifts 64 serial bits into a capture buffer, then
// plays the 8 captured bytes back (plus an offset) one per tick.
module serial_capture_sequencer #(
    parameter logic [23:0] TICK_DIV = 24'd10_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_capture_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_PLAY,
        S_DONE
    } state_e;

    state_e      state_q,     state_d;
    logic [23:0] cnt_q,       cnt_d;
    logic [5:0]  bit_cnt_q,   bit_cnt_d;
    logic [2:0]  byte_idx_q,  byte_idx_d;
    logic [63:0] cap_buf_q,   cap_buf_d;
    logic        busy_q,      busy_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_byte_q,  out_byte_d;
    logic        done_q,      done_d;

    // Tick is only acted on in CAPTURE and PLAY; the counter idles at 0 elsewhere.
    logic tick;
    assign tick = (cnt_q == (TICK_DIV - 24'd1));

    // Next-state, datapath and registered-output computation.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        cap_buf_d   = cap_buf_q;
        out_valid_d = 1'b0;
        out_byte_d  = out_byte_q;

        if (bus.abort) begin
            // Abort beats start and any pending tick; buffer and last byte are kept.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    cnt_d = '0;
                    if (bus.start) begin
                        state_d   = S_CAPTURE;
                        bit_cnt_d = '0;
                    end
                end
                S_CAPTURE: begin
                    cnt_d = tick ? '0 : cnt_q + 24'd1;
                    if (tick) begin
                        // Right shift: the first sampled bit lands in bit 0 after 64 ticks.
                        cap_buf_d = {bus.ser_in, cap_buf_q[63:1]};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd63) begin
                            state_d    = S_PLAY;
                            byte_idx_d = '0;
                        end
                    end
                end
                S_PLAY: begin
                    cnt_d = tick ? '0 : cnt_q + 24'd1;
                    if (tick) begin
                        // Offset is taken live at each playback tick; carry is dropped.
                        out_byte_d  = cap_buf_q[{byte_idx_q, 3'b000} +: 8] + bus.offset;
                        out_valid_d = 1'b1;
                        byte_idx_d  = byte_idx_q + 3'd1;
                        if (byte_idx_q == 3'd7) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d == S_CAPTURE) || (state_d == S_PLAY);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            byte_idx_q  <= '0;
            // NOTE: the capture buffer is plain flops, not a RAM, so it can take a reset value.
            cap_buf_q   <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            cap_buf_q   <= cap_buf_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_serial_capture_sequencer.sv
// Self-checking bench: two sequencers (tick divider 4 and 1) run against a
// behavioural model built from elapsed-cycle arithmetic and a sample array.
module tb_serial_capture_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_capture_sequencer_if if4 ();
    serial_capture_sequencer_if if1 ();

    serial_capture_sequencer #(.TICK_DIV(24'd4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    serial_capture_sequencer #(.TICK_DIV(24'd1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_RUN, M_DONE} mmode_e;
    mmode_e      m_mode [2] = '{M_IDLE, M_IDLE};
    int          m_run  [2];
    logic [63:0] m_samp [2];
    logic [7:0]  m_ob   [2] = '{8'h00, 8'h00};
    logic        m_ov   [2] = '{1'b0, 1'b0};
    logic        m_done [2] = '{1'b0, 1'b0};
    int          tdiv   [2] = '{4, 1};

    // A run is 72 ticks counted from the start edge: ticks 0..63 sample bits,
    // ticks 64..71 emit bytes built from the recorded samples.
    task automatic model_step(input int u, input logic st, input logic ab,
                              input logic si, input logic [7:0] off);
        int k;
        if (rst) begin
            m_mode[u] = M_IDLE;
            m_ob[u]   = 8'h00;
            m_ov[u]   = 1'b0;
            m_done[u] = 1'b0;
            return;
        end
        m_ov[u] = 1'b0;
        if (ab) begin
            m_mode[u] = M_IDLE;
            m_done[u] = 1'b0;
        end else if (m_mode[u] != M_RUN) begin
            if (st) begin
                m_mode[u] = M_RUN;
                m_run[u]  = 0;
                m_done[u] = 1'b0;
            end
        end else begin
            if (m_run[u] % tdiv[u] == tdiv[u] - 1) begin
                k = m_run[u] / tdiv[u];
                if (k < 64) begin
                    m_samp[u][k] = si;
                end else begin
                    m_ob[u] = m_samp[u][8*(k-64) +: 8] + off;
                    m_ov[u] = 1'b1;
                    if (k == 71) begin
                        m_mode[u] = M_DONE;
                        m_done[u] = 1'b1;
                    end
                end
            end
            m_run[u]++;
        end
    endtask

    // Advance the model on every active edge using the inputs the DUTs see.
    always @(posedge clk) begin
        model_step(0, if4.start, if4.abort, if4.ser_in, if4.offset);
        model_step(1, if1.start, if1.abort, if1.ser_in, if1.offset);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output of both DUTs against the model away from the active edge.
    logic prev_ov4 = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("dut4.busy",      {31'd0, if4.busy},      {31'd0, m_mode[0] == M_RUN});
            check("dut4.out_valid", {31'd0, if4.out_valid}, {31'd0, m_ov[0]});
            check("dut4.out_byte",  {24'd0, if4.out_byte},  {24'd0, m_ob[0]});
            check("dut4.done",      {31'd0, if4.done},      {31'd0, m_done[0]});
            check("dut1.busy",      {31'd0, if1.busy},      {31'd0, m_mode[1] == M_RUN});
            check("dut1.out_valid", {31'd0, if1.out_valid}, {31'd0, m_ov[1]});
            check("dut1.out_byte",  {24'd0, if1.out_byte},  {24'd0, m_ob[1]});
            check("dut1.done",      {31'd0, if1.done},      {31'd0, m_done[1]});
            check("dut4.ov_back_to_back", {31'd0, prev_ov4 & if4.out_valid}, 32'd0);
            prev_ov4 = if4.out_valid;
        end
    end

    // Record every playback byte of the divide-by-4 instance.
    logic [7:0] pulses4 [$];
    always @(negedge clk) begin
        if (if4.out_valid) pulses4.push_back(if4.out_byte);
    end

    // Drive one full capture + playback on dut4; optionally pulse start while busy.
    task automatic run_stream(input logic [63:0] pat, input logic [7:0] off, input bit repulse);
        pulses4.delete();
        @(negedge clk);
        if4.start  = 1'b1;
        if4.offset = off;
        @(negedge clk);
        if4.start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if4.ser_in = pat[i];
            if (repulse && (i % 16 == 5)) if4.start = 1'b1;
            @(negedge clk);
            if4.start = 1'b0;
            repeat (3) @(negedge clk);
        end
        for (int c = 0; c < 34; c++) begin
            if4.start  = repulse && (c == 9);
            if4.ser_in = 1'($urandom);
            @(negedge clk);
        end
        if4.start = 1'b0;
    endtask

    task automatic check_bytes(input string name, input logic [63:0] exp);
        check({name, ".count"}, pulses4.size(), 32'd8);
        for (int j = 0; j < 8; j++) begin
            if (j < pulses4.size())
                check({name, ".byte"}, {24'd0, pulses4[j]}, {24'd0, exp[8*j +: 8]});
        end
        check({name, ".done"}, {31'd0, if4.done}, 32'd1);
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin
        logic [63:0] pat;
        logic [63:0] exp;
        int          n;

        rst = 1'b1;
        if4.start = 1'b0; if4.abort = 1'b0; if4.ser_in = 1'b0; if4.offset = 8'h00;
        if1.start = 1'b0; if1.abort = 1'b0; if1.ser_in = 1'b0; if1.offset = 8'h00;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset.busy",      {31'd0, if4.busy},      32'd0);
        check("reset.done",      {31'd0, if4.done},      32'd0);
        check("reset.out_valid", {31'd0, if4.out_valid}, 32'd0);
        check("reset.out_byte",  {24'd0, if4.out_byte},  32'd0);

        // Plain stream, zero offset.
        pat = 64'h0123456789ABCDEF;
        run_stream(pat, 8'h00, 1'b0);
        exp = 64'h0123456789ABCDEF;
        check_bytes("stream_off00", exp);

        // Same stream with an offset that wraps the lowest byte.
        run_stream(pat, 8'h20, 1'b0);
        exp = 64'h21436587A9CBED0F;
        check_bytes("stream_off20", exp);

        // Abort part-way through a capture, then a fresh full capture.
        @(negedge clk);
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        for (int i = 0; i < 41; i++) begin
            if4.ser_in = 1'($urandom);
            @(negedge clk);
        end
        if4.abort = 1'b1;
        @(negedge clk);
        if4.abort = 1'b0;
        check("abort.busy", {31'd0, if4.busy}, 32'd0);
        check("abort.done", {31'd0, if4.done}, 32'd0);
        pat = 64'hFEDCBA9876543210;
        run_stream(pat, 8'h01, 1'b0);
        exp = 64'hFFDDBB9977553311;
        check_bytes("after_abort", exp);

        // start pulses while busy must not disturb the run.
        pat = 64'h0123456789ABCDEF;
        run_stream(pat, 8'h00, 1'b1);
        exp = 64'h0123456789ABCDEF;
        check_bytes("repulse", exp);

        // start and abort together in DONE: abort wins.
        if4.start = 1'b1;
        if4.abort = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        if4.abort = 1'b0;
        @(negedge clk);
        check("start_abort.busy", {31'd0, if4.busy}, 32'd0);
        check("start_abort.done", {31'd0, if4.done}, 32'd0);

        // Divide-by-1: start-to-done counted in cycles, start cycle included.
        if1.offset = 8'($urandom);
        if1.start  = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if1.start  = 1'b0;
            if1.ser_in = 1'($urandom);
            n++;
            if (if1.done) break;
        end
        check("tick1.start_to_done", n, 32'd73);

        // Randomized soak on both instances.
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(1499, 0) == 0);
            if4.ser_in = 1'($urandom);
            if1.ser_in = 1'($urandom);
            if4.start  = ($urandom_range(19, 0) == 0);
            if1.start  = ($urandom_range(9, 0) == 0);
            if4.abort  = ($urandom_range(399, 0) == 0);
            if1.abort  = ($urandom_range(149, 0) == 0);
            if ($urandom_range(15, 0) == 0) if4.offset = 8'($urandom);
            if ($urandom_range(15, 0) == 0) if1.offset = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        if4.start = 1'b0; if4.abort = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends on its own.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
